// File: rtl/pio_cmd_pkg.sv
// -----------------------------------------------------------------------------
// pio_cmd_pkg
// Shared definitions for the PIO command sequencer:
//   - opcode, status and FSM state enums
//   - command / response word field positions
//   - counter and timer widths
//   - a helper that packs the response word
// -----------------------------------------------------------------------------
package pio_cmd_pkg;

  // Command word: [31] req toggle, [30:28] op, [27:0] arg
  localparam int CMD_W    = 32;
  localparam int TGL_BIT  = 31;
  localparam int OP_HI    = 30;
  localparam int OP_LO    = 28;
  localparam int ARG_W    = 28;

  // Response word: [31] ack toggle, [30:28] op, [27:26] status, [25:0] result
  localparam int RESULT_W = 26;

  localparam int N_BTN     = 4;
  localparam int CMD_CNT_W = 16;
  localparam int ERR_CNT_W = 8;
  localparam int TIMER_W   = 32;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WR_RED   = 3'd1,
    OP_WR_GREEN = 3'd2,
    OP_WR_HEX   = 3'd3,
    OP_RD_BTN   = 3'd4,
    OP_RD_STAT  = 3'd5,
    OP_WAIT_BTN = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_RSVD    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_EXEC,
    S_WAIT_BTN,
    S_RESPOND
  } state_e;

  function automatic logic [CMD_W-1:0] pack_rsp(input logic                ack,
                                                 input op_e                 op,
                                                 input status_e             status,
                                                 input logic [RESULT_W-1:0] result);
    return {ack, op, status, result};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Brings the raw active-low KEY inputs into the clock domain, optionally
// debounces them, and emits a one-cycle pulse per button on each press.
//
// Configuration macro: PIO_CMD_DEBOUNCE_EN
//   defined     - each button level is accepted only after DEBOUNCE_CYCLES
//                 consecutive identical synchronised samples (one counter per
//                 button).
//   not defined - the synchronised level feeds the edge detector directly.
//
// Ports:
//   clk          in  clock
//   reset_n      in  asynchronous active-low reset
//   buttons_n_i  in  raw KEY inputs, active-low, asynchronous
//   press_o      out one-cycle press pulse per button (active-high)
// -----------------------------------------------------------------------------
module button_conditioner
  import pio_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] buttons_n_i,
  output logic [N_BTN-1:0] press_o
);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] level_prev_q;

  // Two-flop synchroniser; inverted so that 1 means "pressed".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values;
      // with = the second stage would collapse into the first.
      sync1_q <= ~buttons_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_CMD_DEBOUNCE_EN
  localparam int DB_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_CNT_W-1:0] db_cnt_q [N_BTN];
  logic [N_BTN-1:0]    stable_q;

  // The counter runs while the synchronised sample disagrees with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-button counters are a handful of flops, not a RAM, so
      // they are reset like every other register.
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          stable_q[i] <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;

  // The filter is compiled out; this keeps the shared parameter referenced.
  if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_prev_q <= '0;
    end else begin
      level_prev_q <= level;
    end
  end

  // Rising edge of the pressed level; releases produce nothing.
  assign press_o = level & ~level_prev_q;

endmodule

// File: rtl/pio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pio_cmd_sequencer
// Executes one host command per toggle of host_cmd_i[31] and reports the
// result on host_rsp_o, whose bit 31 echoes the toggle once done. Owns the
// red/green LEDs and the hex display value; tracks sticky button events, a
// command counter and a saturating error counter.
//
// Configuration macro: PIO_CMD_DEBOUNCE_EN (see button_conditioner).
//
// Ports:
//   clk           in  clock, same domain as the PIO registers
//   reset_n       in  asynchronous active-low reset
//   host_cmd_i    in  [31] req toggle, [30:28] op, [27:0] arg
//   host_rsp_o    out [31] ack toggle, [30:28] op, [27:26] status, [25:0] result
//   buttons_n_i   in  raw KEY inputs, active-low
//   red_leds_o    out red LED drive
//   green_leds_o  out green LED drive
//   hex_o         out eight nibbles for the seven-segment decoders
//   busy_o        out high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module pio_cmd_sequencer
  import pio_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int          RED_W           = 18,
  parameter int          GREEN_W         = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CMD_W-1:0]   host_cmd_i,
  output logic [CMD_W-1:0]   host_rsp_o,
  input  logic [N_BTN-1:0]   buttons_n_i,
  output logic [RED_W-1:0]   red_leds_o,
  output logic [GREEN_W-1:0] green_leds_o,
  output logic [31:0]        hex_o,
  output logic               busy_o
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q,    state_d;
  logic                  seen_tgl_q, seen_tgl_d;
  op_e                   op_q,       op_d;
  logic [ARG_W-1:0]      arg_q,      arg_d;
  status_e               status_q,   status_d;
  logic [RESULT_W-1:0]   result_q,   result_d;
  logic [CMD_W-1:0]      rsp_q,      rsp_d;
  logic [RED_W-1:0]      red_q,      red_d;
  logic [GREEN_W-1:0]    green_q,    green_d;
  logic [31:0]           hex_q,      hex_d;
  logic [N_BTN-1:0]      events_q,   events_d;
  logic [CMD_CNT_W-1:0]  cmd_cnt_q,  cmd_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q,  err_cnt_d;
  logic [TIMER_W-1:0]    timer_q,    timer_d;
  logic                  busy_q,     busy_d;
  logic                  events_clr;
  logic [N_BTN-1:0]      press;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_conditioner (
    .clk         (clk),
    .reset_n     (reset_n),
    .buttons_n_i (buttons_n_i),
    .press_o     (press)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so
    // branches that do not mention a signal hold it instead of inferring a latch.
    state_d    = state_q;
    seen_tgl_d = seen_tgl_q;
    op_d       = op_q;
    arg_d      = arg_q;
    status_d   = status_q;
    result_d   = result_q;
    rsp_d      = rsp_q;
    red_d      = red_q;
    green_d    = green_q;
    hex_d      = hex_q;
    cmd_cnt_d  = cmd_cnt_q;
    err_cnt_d  = err_cnt_q;
    timer_d    = timer_q;
    events_clr = 1'b0;

    unique case (state_q)
      // Align to whatever toggle the host left behind so a stale command
      // written before reset is not replayed.
      S_INIT: begin
        seen_tgl_d     = host_cmd_i[TGL_BIT];
        rsp_d[TGL_BIT] = host_cmd_i[TGL_BIT];
        state_d        = S_IDLE;
      end

      S_IDLE: begin
        if (host_cmd_i[TGL_BIT] != seen_tgl_q) begin
          seen_tgl_d = host_cmd_i[TGL_BIT];
          op_d       = op_e'(host_cmd_i[OP_HI:OP_LO]);
          arg_d      = host_cmd_i[ARG_W-1:0];
          state_d    = S_EXEC;
        end
      end

      S_EXEC: begin
        cmd_cnt_d = cmd_cnt_q + CMD_CNT_W'(1);
        status_d  = ST_OK;
        result_d  = '0;
        state_d   = S_RESPOND;
        case (op_q)
          OP_NOP:      ;
          OP_WR_RED:   red_d       = arg_q[RED_W-1:0];
          OP_WR_GREEN: green_d     = arg_q[GREEN_W-1:0];
          OP_WR_HEX:   hex_d[27:0] = arg_q;
          OP_RD_BTN: begin
            result_d   = {{(RESULT_W-N_BTN){1'b0}}, events_q};
            events_clr = 1'b1;
          end
          // Reports the counter values from before this command counts.
          OP_RD_STAT:  result_d = {2'b00, err_cnt_q, cmd_cnt_q};
          OP_WAIT_BTN: begin
            timer_d = '0;
            state_d = S_WAIT_BTN;
          end
          OP_ILLEGAL: begin
            status_d = ST_ERR;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      // A press in the same cycle as the last timer tick still counts as a press.
      S_WAIT_BTN: begin
        if (|press) begin
          status_d   = ST_OK;
          result_d   = {{(RESULT_W-N_BTN){1'b0}}, events_q | press};
          events_clr = 1'b1;
          state_d    = S_RESPOND;
        end else if (timer_q == TIMEOUT_LAST) begin
          status_d = ST_TIMEOUT;
          result_d = '0;
          state_d  = S_RESPOND;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      S_RESPOND: begin
        rsp_d   = pack_rsp(seen_tgl_q, op_q, status_q, result_q);
        state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase

    // A press landing in the same cycle as a clear survives.
    events_d = (events_q & ~{N_BTN{events_clr}}) | press;

    // Registered so busy_o is low while reset holds the FSM in INIT.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      seen_tgl_q <= 1'b0;
      op_q       <= OP_NOP;
      arg_q      <= '0;
      status_q   <= ST_OK;
      result_q   <= '0;
      rsp_q      <= '0;
      red_q      <= '0;
      green_q    <= '0;
      hex_q      <= '0;
      events_q   <= '0;
      cmd_cnt_q  <= '0;
      err_cnt_q  <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_tgl_q <= seen_tgl_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      status_q   <= status_d;
      result_q   <= result_d;
      rsp_q      <= rsp_d;
      red_q      <= red_d;
      green_q    <= green_d;
      hex_q      <= hex_d;
      events_q   <= events_d;
      cmd_cnt_q  <= cmd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
    end
  end

  assign host_rsp_o   = rsp_q;
  assign red_leds_o   = red_q;
  assign green_leds_o = green_q;
  assign hex_o        = hex_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pio_cmd_sequencer
// Directed bench for pio_cmd_sequencer (default build, no debounce), with
// TIMEOUT_CYCLES = 100. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so every sample sees settled post-edge values.
// -----------------------------------------------------------------------------
module tb_pio_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] host_cmd_i;
  logic [31:0] host_rsp_o;
  logic [3:0]  buttons_n_i;
  logic [17:0] red_leds_o;
  logic [8:0]  green_leds_o;
  logic [31:0] hex_o;
  logic        busy_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pio_cmd_sequencer #(
    .TIMEOUT_CYCLES  (100),
    .DEBOUNCE_CYCLES (4),
    .RED_W           (18),
    .GREEN_W         (9)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .host_cmd_i   (host_cmd_i),
    .host_rsp_o   (host_rsp_o),
    .buttons_n_i  (buttons_n_i),
    .red_leds_o   (red_leds_o),
    .green_leds_o (green_leds_o),
    .hex_o        (hex_o),
    .busy_o       (busy_o)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a command and wait the three cycles to its response.
  task automatic issue(input logic [31:0] cmd);
    host_cmd_i = cmd;
    step(3);
  endtask

  initial begin
    logic seen_busy;

    // ---- reset with a stale toggle already set by the host ----
    reset_n     = 1'b0;
    host_cmd_i  = 32'h8000_0000;
    buttons_n_i = 4'hF;
    step(3);
    check("reset_rsp",   host_rsp_o, 32'h0000_0000);
    check("reset_busy",  {31'b0, busy_o}, 32'd0);
    check("reset_red",   {14'b0, red_leds_o}, 32'd0);
    reset_n = 1'b1;
    step(1);
    check("init_ack",    host_rsp_o, 32'h8000_0000);
    step(5);
    check("init_noreplay_busy", {31'b0, busy_o}, 32'd0);
    check("init_noreplay_rsp",  host_rsp_o, 32'h8000_0000);

    // ---- WR_RED with cycle-accurate latency ----
    host_cmd_i = 32'h1003_FFFF;
    step(1);
    check("wr_red_exec_busy", {31'b0, busy_o}, 32'd1);
    check("wr_red_exec_red",  {14'b0, red_leds_o}, 32'd0);
    step(1);
    check("wr_red_n2_red",    {14'b0, red_leds_o}, 32'h0003_FFFF);
    check("wr_red_n2_rsp",    host_rsp_o, 32'h8000_0000);
    step(1);
    check("wr_red_n3_rsp",    host_rsp_o, 32'h1000_0000);
    check("wr_red_n3_busy",   {31'b0, busy_o}, 32'd0);

    // ---- illegal op, then status read ----
    issue(32'hF000_0000);
    check("illegal_rsp", host_rsp_o, 32'hF400_0000);
    issue(32'h5000_0000);
    check("rd_stat_rsp", host_rsp_o, 32'h5001_0002);

    // ---- green (truncated arg) and hex (top nibble kept) ----
    issue(32'hA000_0ABC);
    check("wr_green_rsp", host_rsp_o, 32'hA000_0000);
    check("wr_green_led", {23'b0, green_leds_o}, 32'h0000_00BC);
    issue(32'h3FED_CBA9);
    check("wr_hex_rsp",   host_rsp_o, 32'h3000_0000);
    check("wr_hex_val",   hex_o, 32'h0FED_CBA9);
    check("red_held",     {14'b0, red_leds_o}, 32'h0003_FFFF);

    // ---- host rewrites the word while busy with the same toggle ----
    host_cmd_i = 32'h8000_0000;
    step(1);
    host_cmd_i = 32'h9000_0005;
    step(6);
    check("busy_write_rsp",  host_rsp_o, 32'h8000_0000);
    check("busy_write_red",  {14'b0, red_leds_o}, 32'h0003_FFFF);
    check("busy_write_idle", {31'b0, busy_o}, 32'd0);

    // ---- KEY2 press, read twice ----
    buttons_n_i = 4'b1011;
    step(6);
    buttons_n_i = 4'hF;
    step(6);
    issue(32'h4000_0000);
    check("rd_btn_first",  host_rsp_o, 32'h4000_0004);
    issue(32'hC000_0000);
    check("rd_btn_second", host_rsp_o, 32'hC000_0000);

    // ---- WAIT_BTN timeout: RESPOND 100 cycles after entering the wait ----
    host_cmd_i = 32'h6000_0000;
    step(102);
    check("wait_to_early_rsp",  host_rsp_o, 32'hC000_0000);
    check("wait_to_early_busy", {31'b0, busy_o}, 32'd1);
    step(1);
    check("wait_to_rsp",  host_rsp_o, 32'h6800_0000);
    check("wait_to_busy", {31'b0, busy_o}, 32'd0);

    // ---- WAIT_BTN with KEY0 pressed 20 cycles into the wait ----
    host_cmd_i = 32'hE000_0000;
    step(22);
    buttons_n_i = 4'b1110;
    for (int i = 0; i < 40 && busy_o; i++) step(1);
    check("wait_press_done", {31'b0, busy_o}, 32'd0);
    check("wait_press_rsp",  host_rsp_o, 32'hE000_0001);
    buttons_n_i = 4'hF;
    step(6);

    // ---- reset during WAIT_BTN aborts without a response ----
    host_cmd_i = 32'h6000_0000;
    step(10);
    check("abort_busy_before", {31'b0, busy_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_rsp",   host_rsp_o, 32'h0000_0000);
    check("abort_red",   {14'b0, red_leds_o}, 32'd0);
    check("abort_green", {23'b0, green_leds_o}, 32'd0);
    check("abort_hex",   hex_o, 32'd0);
    check("abort_busy",  {31'b0, busy_o}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("abort_init_rsp", host_rsp_o, 32'h0000_0000);
    seen_busy = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (busy_o) seen_busy = 1'b1;
    end
    check("abort_no_replay", {31'b0, seen_busy}, 32'd0);
    issue(32'hD000_0000);
    check("abort_counters_clear", host_rsp_o, 32'hD000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
